// File: rtl/fp_add_cdb_stage_pkg.sv
// Shared definitions for the FADD execution unit: FP field constants, op
// encodings and the combinational single-precision adder used before stage 0.
package fp_add_cdb_stage_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // IEEE-754 single add, round-to-nearest-even, denormals supported.
  // Operands are pre-signed: subtraction is done by the caller flipping B's sign.
  function automatic logic [31:0] fp_add32(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s, res;
    logic [9:0]  el, es, e, diff;
    logic [23:0] ml, ms;
    logic [4:0]  dc, lz, sh;
    logic [49:0] ext;
    logic [26:0] lm, sm, r;
    logic [27:0] sum;
    logic [24:0] mr;
    logic        sub, rup, a_inf, b_inf, a_nan, b_nan;
    a_inf = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[MAN_W-1:0] == '0);
    b_inf = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[MAN_W-1:0] == '0);
    a_nan = (a[EXP_MSB:EXP_LSB] == 8'hFF) && (a[MAN_W-1:0] != '0);
    b_nan = (b[EXP_MSB:EXP_LSB] == 8'hFF) && (b[MAN_W-1:0] != '0);
    res = POS_ZERO;
    lz  = '0;
    sh  = '0;
    sum = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[SIGN_BIT] != b[SIGN_BIT]))) begin
      res = QNAN;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else begin
      // order by magnitude so the subtract never goes negative
      if (a[30:0] >= b[30:0]) begin
        l = a; s = b;
      end else begin
        l = b; s = a;
      end
      el   = (l[EXP_MSB:EXP_LSB] == 8'h00) ? 10'd1 : {2'b00, l[EXP_MSB:EXP_LSB]};
      es   = (s[EXP_MSB:EXP_LSB] == 8'h00) ? 10'd1 : {2'b00, s[EXP_MSB:EXP_LSB]};
      ml   = {l[EXP_MSB:EXP_LSB] != 8'h00, l[MAN_W-1:0]};
      ms   = {s[EXP_MSB:EXP_LSB] != 8'h00, s[MAN_W-1:0]};
      diff = el - es;
      dc   = (diff > 10'd31) ? 5'd31 : diff[4:0];
      // align smaller operand; everything shifted past the round bit folds into sticky
      ext  = {ms, 26'b0} >> dc;
      sm   = {ext[49:24], |ext[23:0]};
      lm   = {ml, 3'b000};
      sub  = l[SIGN_BIT] ^ s[SIGN_BIT];
      e    = el;
      if (!sub) begin
        sum = {1'b0, lm} + {1'b0, sm};
        if (sum[27]) begin
          r = {sum[27:2], |sum[1:0]};
          e = el + 10'd1;
        end else begin
          r = sum[26:0];
        end
      end else begin
        r = lm - sm;
        for (int i = 0; i < 27; i++)
          if (r[i]) lz = 5'(26 - i);
        // never normalise below the minimum exponent: that is a denormal
        sh = (el > {5'b0, lz}) ? lz : 5'(el - 10'd1);
        r  = r << sh;
        e  = el - {5'b0, sh};
      end
      rup = r[2] & (r[1] | r[0] | r[3]);
      mr  = {1'b0, r[26:3]} + {24'b0, rup};
      if (mr[24]) begin
        mr = mr >> 1;
        e  = e + 10'd1;
      end
      if (sub && (r == '0))
        res = POS_ZERO;
      else if (e >= 10'd255)
        res = {l[SIGN_BIT], 8'hFF, 23'h0};
      else
        res = {l[SIGN_BIT], (mr[23] ? e[7:0] : 8'h00), mr[22:0]};
    end
    return res;
  endfunction

  // Zero-cleaning wrapper: exact-zero operands bypass the adder and
  // zero/denormal adder results are flushed to +0.
  function automatic logic [31:0] fp_add32_zfix(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic        a_zero, b_zero;
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    if (a_zero && b_zero)   res = POS_ZERO;
    else if (a_zero)        res = b;
    else if (b_zero)        res = a;
    else begin
      res = fp_add32(a, b);
      if (res[EXP_MSB:EXP_LSB] == 8'h00) res = POS_ZERO;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_add_cdb_stage_if.sv
// Issue and CDB handshake bundle between the FP-add reservation station,
// the FADD execution unit and the CDB arbiter.
interface fp_add_cdb_stage_if #(parameter int TAG_W = 4) ();
  logic             issue_valid;
  logic             issue_ready;
  logic             issue_op;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_req;
  logic             cdb_grant;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  modport master (
    output issue_valid, issue_op, issue_a, issue_b, issue_tag, cdb_grant,
    input  issue_ready, cdb_req, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b, issue_tag, cdb_grant,
    output issue_ready, cdb_req, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/fp_result_fifo.sv
// Result buffer between the execute pipeline and the CDB: synchronous FIFO
// with flush; simultaneous push and pop are both honoured.
module fp_result_fifo #(
  parameter  int W     = 36,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;

  // pointer and occupancy update; flush empties the buffer outright
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  // control state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/fp_add_cdb_stage.sv
// FADD execution unit for the Tomasulo FP-add path: combinational adder,
// fixed-latency tag/result pipeline, credit-limited result FIFO and a
// req/grant CDB broadcast port.
// Optional build macro FADD_ZERO_FIX_EN: bypass exact-zero operands and
// flush zero/denormal adder results to +0.
module fp_add_cdb_stage
  import fp_add_cdb_stage_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fp_add_cdb_stage_if.slave   bus,
  output logic                busy
);
  localparam int ENT_W = TAG_W + 32;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][ENT_W-1:0] ent_pipe_q, ent_pipe_d;
  logic                          cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]              cdb_tag_q, cdb_tag_d;
  logic [31:0]                   cdb_data_q, cdb_data_d;

  logic [ENT_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_empty;
  logic [3:0]       inflight;
  logic [4:0]       outstanding;
  logic             accept, push, pop;
  logic [31:0]      b_eff, add_res;

  // operand formation and add; the result is captured at the accept edge
  always_comb begin
    b_eff = {bus.issue_b[SIGN_BIT] ^ (bus.issue_op == OP_SUB), bus.issue_b[30:0]};
`ifdef FADD_ZERO_FIX_EN
    add_res = fp_add32_zfix(bus.issue_a, b_eff);
`else
    add_res = fp_add32(bus.issue_a, b_eff);
`endif
  end

  // credits: in-flight ops plus buffered results, from registered state only,
  // so a pop frees its credit one cycle later
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++)
      inflight = inflight + {3'b000, vld_pipe_q[k]};
    outstanding = {1'b0, inflight} + 5'(fifo_cnt);
  end

  assign bus.issue_ready = (outstanding < 5'(FIFO_DEPTH));
  assign busy            = (outstanding != '0);
  assign bus.cdb_req     = !fifo_empty;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_tag     = cdb_tag_q;
  assign bus.cdb_data    = cdb_data_q;

  // flush takes priority over accept, push and grant
  assign accept = bus.issue_valid && bus.issue_ready && !flush;
  assign push   = vld_pipe_q[LATENCY-1] && !flush;
  assign pop    = bus.cdb_req && bus.cdb_grant && !flush;

  // stall-free shift pipeline and CDB broadcast register next-state
  always_comb begin
    vld_pipe_d    = '0;
    ent_pipe_d    = ent_pipe_q;
    vld_pipe_d[0] = accept;
    ent_pipe_d[0] = accept ? {bus.issue_tag, add_res} : ent_pipe_q[0];
    for (int k = 1; k < LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      ent_pipe_d[k] = ent_pipe_q[k-1];
    end
    if (flush) vld_pipe_d = '0;
    cdb_valid_d = pop;
    cdb_tag_d   = pop ? fifo_head[ENT_W-1:32] : cdb_tag_q;
    cdb_data_d  = pop ? fifo_head[31:0]       : cdb_data_q;
  end

  // state registers; rst also clears the broadcast tag/data, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      ent_pipe_q  <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      ent_pipe_q  <= ent_pipe_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  fp_result_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (ent_pipe_q[LATENCY-1]),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_cnt),
    .empty   (fifo_empty)
  );
endmodule

// File: doc/fp_add_cdb_stage.md
Name: fp_add_cdb_stage

Overview:
- Multi-cycle FP add/sub execution unit for the Tomasulo FADD path.
- Accepts issued, tagged single-precision operand pairs from the FP-add reservation station.
- Computes each result by instantiating the existing combinational 32-bit FP adder, then delays it through a fixed-latency pipeline.
- Buffers finished results and arbitrates for the common data bus (CDB) with a req/grant handshake.

Parameters:
- TAG_W, 4, width of the reservation-station tag.
- LATENCY, 3, execute pipeline depth in cycles (legal range 1..8).
- FIFO_DEPTH, 2, result buffer entries; also the maximum number of outstanding operations (legal range 1..4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all in-flight and buffered results (mispredict/exception).
- issue_valid  in  1  reservation station presents an operation.
- issue_ready  out  1  unit can accept this cycle.
- issue_op  in  1  0 = A+B, 1 = A-B.
- issue_a  in  32  IEEE-754 single operand A.
- issue_b  in  32  IEEE-754 single operand B.
- issue_tag  in  TAG_W  destination tag.
- cdb_req  out  1  request CDB slot.
- cdb_grant  in  1  CDB arbiter grant.
- cdb_valid  out  1  broadcast strobe.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  32  broadcast result.
- busy  out  1  any op in pipeline or FIFO.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset: all pipeline valid bits 0, FIFO empty, credit count 0. Outputs: issue_ready=1, cdb_req=0, cdb_valid=0, cdb_tag=0, cdb_data=0, busy=0.
- Accept: an operation is accepted when issue_valid && issue_ready at a rising edge. When issue_valid is low or issue_ready is low, inputs are ignored.
- Operand formation: for issue_op=1, B's sign bit is inverted before the adder. The adder is combinational on the issue inputs.
- Pipeline capture: stage 0 captures {tag, result} at the accept edge T. Stage k loads from stage k-1 at edge T+k. The last stage writes the FIFO at edge T+LATENCY.
- Pipeline stalls: none. Credits guarantee FIFO space.
- Credits:
  - outstanding = in-flight ops + FIFO count.
  - issue_ready = (outstanding < FIFO_DEPTH), computed combinationally from registered counts.
  - A pop in the same cycle does not free a credit until the next cycle.
- CDB request: cdb_req = FIFO non-empty, presented from the cycle after the write edge. Minimum issue-to-cdb_req is LATENCY+1 edges.
- CDB broadcast:
  - On a cycle with cdb_req && cdb_grant, the head entry is popped at that edge.
  - cdb_valid is registered high for exactly the following cycle, with cdb_tag/cdb_data = popped entry.
  - Otherwise cdb_valid=0; tag and data hold their last values.
  - cdb_grant while cdb_req=0 is ignored.
- FIFO ordering: FIFO order equals issue order. Pointers wrap modulo FIFO_DEPTH. A push and a pop on the same edge are both honoured, with count unchanged.
- Flush: clears all valid bits, the FIFO and the credits at the edge; cdb_valid=0 next cycle. flush wins over a simultaneous accept, push, or grant (the grant is not consumed).
- rst behaves like flush and additionally clears tag and data registers. rst asserted mid-operation discards everything.
- busy = outstanding != 0.

Optional Feature:
- FADD_ZERO_FIX_EN
- Defined:
  - Operand with exponent==0 and mantissa==0 (±0) bypasses the adder; the result is the other (sign-adjusted) operand, or +0 if both are zero.
  - Any adder result whose exponent field is 0 is forced to +0 (0x00000000).
  - The bypass is a mux before stage 0, so latency is unchanged.
- Undefined: the raw adder output is used unmodified.

Decomposition:
- Shared header fp_defs.vh holds:
  - FP field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23.
  - OP_ADD=0, OP_SUB=1.
  - POS_ZERO=32'h0.
- One sub-module, fp_result_fifo: synchronous FIFO with push/pop, count and flush, parameterised on data width (TAG_W+32) and depth.
- Pipeline, credit counter and CDB logic stay in the top module.

Test Plan:
- Add, LATENCY=3: op=0, A=0x3F800000, B=0x40000000, tag=5 -> cdb_req rises 4 edges after accept; after grant, one-cycle cdb_valid with tag=5, data=0x40400000.
- Subtract: op=1, A=0x40400000, B=0x3F800000, tag=2 -> data=0x40000000.
- Backpressure: issue three ops back-to-back, FIFO_DEPTH=2, cdb_grant=0 -> issue_ready low after two accepts. Third accepted only the cycle after the first grant. Broadcast order is tags 1, 2, 3.
- Grant held high continuously with a 4-op stream -> one cdb_valid per result, no duplicates or drops, issue order preserved.
- flush asserted with two ops in flight and one buffered, same cycle as issue_valid -> no cdb_valid ever for those tags; issue_ready=1 and busy=0 the next cycle.
- With FADD_ZERO_FIX_EN: op=0, A=0x40A00000, B=0xC0A00000 -> data=0x00000000; A=0x00000000, B=0xBF800000 -> data=0xBF800000.
